wvb_overflow_arbiter: RTL and testbench
=======================================

# wvb_overflow_arbiter

Round-robin controller that drains overflow-deadtime records from the per-channel waveform buffers. Each buffer raises `overflow_fifo_req` while it holds an unread overflow record (start/end LTC). This block grants one channel at a time, latches that channel's record, presents it on a valid/ready output toward the readout path, and pulses that channel's ack to pop the record. It sits between the 24 channel `waveform_buffer` instances and the readout/register logic.

## Interface
Parameters:
- `P_N_CHAN`, 24, number of waveform buffers served
- `P_CHAN_WIDTH`, 5, width of channel index (ceil log2 `P_N_CHAN`)
- `P_LTC_WIDTH`, 49, LTC timestamp width
- `P_CNT_WIDTH`, 32, record counter width

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  grant enable; low blocks new grants, and an in-progress transaction completes
- `ovf_req`  in  `P_N_CHAN`  per-channel `overflow_fifo_req`
- `ovf_start_ltc`  in  `P_N_CHAN*P_LTC_WIDTH`  flattened start LTCs; channel i at bits [i*W +: W]
- `ovf_end_ltc`  in  `P_N_CHAN*P_LTC_WIDTH`  flattened end LTCs, same packing
- `ovf_ack`  out  `P_N_CHAN`  one-hot, single-cycle ack pulse to `overflow_fifo_ack`
- `rec_valid`  out  1  record available
- `rec_ready`  in  1  consumer accepts record
- `rec_chan`  out  `P_CHAN_WIDTH`  channel of presented record
- `rec_start_ltc`  out  `P_LTC_WIDTH`  overflow start LTC
- `rec_end_ltc`  out  `P_LTC_WIDTH`  overflow end LTC
- `rec_count`  out  `P_CNT_WIDTH`  records accepted since reset; wraps modulo 2^`P_CNT_WIDTH`
- `busy`  out  1  state machine not in IDLE

## Operation
- Buffer contract: `ovf_req[i]` is high while channel i's record FIFO is non-empty, and its LTCs are stable while `ovf_req` is high. One `ovf_ack[i]` pulse pops one entry. The new `ovf_req` and LTC values are valid 2 cycles after the ack pulse.
- State machine (all transitions registered):
  - IDLE: if `en` and any `ovf_req` is high, pick the first requesting channel at or after `rr_ptr` (wrapping), register it as `grant`, and go to CAPTURE.
  - CAPTURE: if `ovf_req[grant]` is still high, latch `rec_chan`, `rec_start_ltc` and `rec_end_ltc`, and go to PRESENT. Otherwise, return to IDLE with no record and no ack.
  - PRESENT: `rec_valid`=1. Outputs are held stable until `rec_ready`. On `rec_valid && rec_ready`, increment `rec_count` and go to ACK.
  - ACK: `ovf_ack[grant]`=1 for exactly this cycle, `rr_ptr` ← `grant`+1 (wraps to 0 after `P_N_CHAN`-1), then go to HOLD.
  - HOLD: one cycle; `ovf_req[grant]` is ignored; then go to IDLE.
- Once PRESENT is entered, the record is committed. A drop of `ovf_req[grant]` during PRESENT does not withdraw `rec_valid`, and the ack is still issued (the buffer ignores an ack on an empty FIFO).
- `en` falling during CAPTURE, PRESENT, ACK or HOLD does not abort the transaction.
- Fairness: a channel with continuous requests waits at most `P_N_CHAN`-1 transactions for its grant.

## Timing
- Reset values: `ovf_ack`=0, `rec_valid`=0, `rec_chan`=0, both LTC outputs 0, `rec_count`=0, `busy`=0, `rr_ptr`=0, state=IDLE.
- Latency: `ovf_req` high at edge n (state IDLE) gives `rec_valid` high from edge n+2.
- With `rec_ready` tied high, the ack pulse occurs at cycle n+3 and the next grant decision at n+5, for a throughput of 1 record per 5 cycles.
- `rec_valid` drops the cycle after acceptance.
- `ovf_ack` is a registered output, glitch-free and one-hot.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronously). The un-acked record remains in its buffer and is re-served after reset, so no record is lost or duplicated.
- Simultaneous requests at reset release: channel 0 is served first.

## Structure
- Package `wvb_ovf_arb_pkg`:
  - state encoding constants `S_IDLE`, `S_CAPTURE`, `S_PRESENT`, `S_ACK`, `S_HOLD`
  - default widths (`P_N_CHAN`, `P_LTC_WIDTH`, `P_CHAN_WIDTH`)
- Sub-module `rr_priority_pick`: combinational round-robin picker taking request vector and `rr_ptr`, producing a found flag and channel index. The pointer register stays in the top level.

## Test plan
- Single request: `ovf_req[3]`=1, start 100, end 250, `rec_ready`=1 -> `rec_valid` at +2, `rec_chan`=3, LTCs 100/250, `ovf_ack[3]` one pulse at +3, `rec_count`=1.
- Round robin: channels 0, 5 and 23 request continuously -> grant order 0, 5, 23, 0; each ack is one-hot and 5 cycles apart.
- Backpressure: `rec_ready`=0 for 20 cycles -> `rec_valid` and LTCs held constant and no ack; on `rec_ready`=1, acceptance then ack on the next cycle.
- Withdrawn request: `ovf_req[7]` pulsed for 1 cycle -> CAPTURE sees it low, returns to IDLE, and no `rec_valid` or ack is issued.
- Reset mid-PRESENT: async `rst` pulse -> outputs zero immediately; after release, the same record (same channel and LTCs) is presented once.
- Enable and wrap: `en`=0 with requests pending -> `busy`=0 and no grants; then `en`=1 with `rec_count` preloaded by forcing to 2^32-1 -> after one record, `rec_count`=0.

Source files
------------

// File: rtl/wvb_ovf_arb_pkg.sv
// Shared state encoding and default widths for the overflow-record arbiter.
package wvb_ovf_arb_pkg;

  localparam int P_N_CHAN     = 24;
  localparam int P_CHAN_WIDTH = 5;
  localparam int P_LTC_WIDTH  = 49;
  localparam int P_CNT_WIDTH  = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_PRESENT = 3'd2,
    S_ACK     = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first requesting channel at or after
// the pointer, scanning upward and wrapping past the last channel.
module rr_priority_pick #(
  parameter int P_N_CHAN     = 24,
  parameter int P_CHAN_WIDTH = 5
) (
  input  logic [P_N_CHAN-1:0]     i_req,
  input  logic [P_CHAN_WIDTH-1:0] i_ptr,
  output logic                    o_found,
  output logic [P_CHAN_WIDTH-1:0] o_idx
);

  int w_scan;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_scan  = 0;
    for (int i = 0; i < P_N_CHAN; i++) begin
      w_scan = int'(i_ptr) + i;
      if (w_scan >= P_N_CHAN) w_scan = w_scan - P_N_CHAN;
      if (!o_found && i_req[w_scan]) begin
        o_found = 1'b1;
        o_idx   = P_CHAN_WIDTH'(w_scan);
      end
    end
  end

endmodule

// File: rtl/wvb_overflow_arbiter.sv
// Drains overflow-deadtime records from the waveform buffers one channel at a
// time and presents each on a valid/ready port, popping it with an ack pulse.
module wvb_overflow_arbiter #(
  parameter int P_N_CHAN     = wvb_ovf_arb_pkg::P_N_CHAN,
  parameter int P_CHAN_WIDTH = wvb_ovf_arb_pkg::P_CHAN_WIDTH,
  parameter int P_LTC_WIDTH  = wvb_ovf_arb_pkg::P_LTC_WIDTH,
  parameter int P_CNT_WIDTH  = wvb_ovf_arb_pkg::P_CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [P_N_CHAN-1:0]             ovf_req,
  input  logic [P_N_CHAN*P_LTC_WIDTH-1:0] ovf_start_ltc,
  input  logic [P_N_CHAN*P_LTC_WIDTH-1:0] ovf_end_ltc,
  output logic [P_N_CHAN-1:0]             ovf_ack,
  output logic                            rec_valid,
  input  logic                            rec_ready,
  output logic [P_CHAN_WIDTH-1:0]         rec_chan,
  output logic [P_LTC_WIDTH-1:0]          rec_start_ltc,
  output logic [P_LTC_WIDTH-1:0]          rec_end_ltc,
  output logic [P_CNT_WIDTH-1:0]          rec_count,
  output logic                            busy
);

  import wvb_ovf_arb_pkg::*;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [P_CHAN_WIDTH-1:0] r_grant;
  logic [P_CHAN_WIDTH-1:0] r_rr_ptr;
  logic [P_N_CHAN-1:0]     r_ovf_ack;
  logic                    r_rec_valid;
  logic [P_CHAN_WIDTH-1:0] r_rec_chan;
  logic [P_LTC_WIDTH-1:0]  r_rec_start_ltc;
  logic [P_LTC_WIDTH-1:0]  r_rec_end_ltc;
  logic [P_CNT_WIDTH-1:0]  r_rec_count;

  logic                    w_pick_found;
  logic [P_CHAN_WIDTH-1:0] w_pick_idx;
  logic                    w_grant_req;
  logic [P_N_CHAN-1:0]     w_grant_onehot;

  rr_priority_pick #(
    .P_N_CHAN     (P_N_CHAN),
    .P_CHAN_WIDTH (P_CHAN_WIDTH)
  ) u_pick (
    .i_req   (ovf_req),
    .i_ptr   (r_rr_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  assign w_grant_req    = ovf_req[r_grant];
  assign w_grant_onehot = {{(P_N_CHAN-1){1'b0}}, 1'b1} << r_grant;

  // NOTE: every variable in a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:    if (en && w_pick_found) w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = w_grant_req ? S_PRESENT : S_IDLE;
      S_PRESENT: if (r_rec_valid && rec_ready) w_next_state = S_ACK;
      S_ACK:     w_next_state = S_HOLD;
      S_HOLD:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_grant         <= '0;
      r_rr_ptr        <= '0;
      r_ovf_ack       <= '0;
      r_rec_valid     <= 1'b0;
      r_rec_chan      <= '0;
      r_rec_start_ltc <= '0;
      r_rec_end_ltc   <= '0;
      r_rec_count     <= '0;
    end else begin
      r_state     <= w_next_state;
      r_rec_valid <= (w_next_state == S_PRESENT);
      r_ovf_ack   <= (w_next_state == S_ACK) ? w_grant_onehot : '0;

      if (r_state == S_IDLE && w_next_state == S_CAPTURE)
        r_grant <= w_pick_idx;

      // Record is committed here; later drops of the request cannot withdraw it.
      if (r_state == S_CAPTURE && w_next_state == S_PRESENT) begin
        r_rec_chan      <= r_grant;
        r_rec_start_ltc <= ovf_start_ltc[int'(r_grant)*P_LTC_WIDTH +: P_LTC_WIDTH];
        r_rec_end_ltc   <= ovf_end_ltc[int'(r_grant)*P_LTC_WIDTH +: P_LTC_WIDTH];
      end

      if (r_state == S_PRESENT && w_next_state == S_ACK)
        r_rec_count <= r_rec_count + 1'b1;

      if (r_state == S_ACK)
        r_rr_ptr <= (r_grant == P_CHAN_WIDTH'(P_N_CHAN-1)) ? '0 : r_grant + 1'b1;
    end
  end

  assign ovf_ack       = r_ovf_ack;
  assign rec_valid     = r_rec_valid;
  assign rec_chan      = r_rec_chan;
  assign rec_start_ltc = r_rec_start_ltc;
  assign rec_end_ltc   = r_rec_end_ltc;
  assign rec_count     = r_rec_count;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_wvb_overflow_arbiter.sv
// Directed bench for wvb_overflow_arbiter: a table of single-channel records
// plus hand-written sequences for round robin, backpressure and reset corners.
module tb_wvb_overflow_arbiter;

  localparam int NC = 24;
  localparam int CW = 5;
  localparam int LW = 49;
  localparam int KW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [NC-1:0]    ovf_req;
  logic [NC*LW-1:0] ovf_start_ltc;
  logic [NC*LW-1:0] ovf_end_ltc;
  logic [NC-1:0]    ovf_ack;
  logic             rec_valid;
  logic             rec_ready;
  logic [CW-1:0]    rec_chan;
  logic [LW-1:0]    rec_start_ltc;
  logic [LW-1:0]    rec_end_ltc;
  logic [KW-1:0]    rec_count;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  wvb_overflow_arbiter #(
    .P_N_CHAN(NC), .P_CHAN_WIDTH(CW), .P_LTC_WIDTH(LW), .P_CNT_WIDTH(KW)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .ovf_req(ovf_req), .ovf_start_ltc(ovf_start_ltc), .ovf_end_ltc(ovf_end_ltc),
    .ovf_ack(ovf_ack), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_chan(rec_chan), .rec_start_ltc(rec_start_ltc), .rec_end_ltc(rec_end_ltc),
    .rec_count(rec_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          chan;
    logic [48:0] start_ltc;
    logic [48:0] end_ltc;
    int          exp_latency;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_rec(input int ch, input logic [48:0] s, input logic [48:0] e);
    ovf_start_ltc[ch*LW +: LW] = s;
    ovf_end_ltc[ch*LW +: LW]   = e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ovf_req = '0;
    en = 1'b1;
    rec_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for rec_valid, sampling on falling edges.
  task automatic wait_valid(input int max_cyc, output int k, output bit ok);
    k = 0;
    ok = 1'b0;
    while (!ok && k < max_cyc) begin
      @(negedge clk);
      k++;
      if (rec_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_ack(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      @(negedge clk);
      if (ovf_ack != '0) ok = 1'b1;
    end
  endtask

  initial begin
    int k;
    bit ok;
    int bad;
    int n_seen;
    int order[4];
    int at[4];
    int n_valid, n_ack, saw_busy;
    logic [CW-1:0] got_chan;
    logic [LW-1:0] got_s, got_e;

    vecs[0] = '{chan: 3,  start_ltc: 49'd100, end_ltc: 49'd250, exp_latency: 3, exp_count: 32'd1};
    vecs[1] = '{chan: 0,  start_ltc: 49'h0_0000_DEAD_BEEF, end_ltc: 49'h0_0000_FEED_F00D, exp_latency: 3, exp_count: 32'd2};
    vecs[2] = '{chan: 23, start_ltc: 49'h1_FFFF_FFFF_FFFF, end_ltc: 49'd0, exp_latency: 3, exp_count: 32'd3};
    vecs[3] = '{chan: 17, start_ltc: 49'h0_1234_5678_9ABC, end_ltc: 49'h1_0000_0000_0001, exp_latency: 3, exp_count: 32'd4};

    rst = 1'b1;
    en = 1'b1;
    ovf_req = '0;
    ovf_start_ltc = '0;
    ovf_end_ltc = '0;
    rec_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack",   ovf_ack, 0);
    check("rst_valid", rec_valid, 0);
    check("rst_chan",  rec_chan, 0);
    check("rst_start", rec_start_ltc, 0);
    check("rst_end",   rec_end_ltc, 0);
    check("rst_count", rec_count, 0);
    check("rst_busy",  busy, 0);
    rst = 1'b0;

    // Single-record transactions with rec_ready tied high.
    for (int t = 0; t < 4; t++) begin
      set_rec(vecs[t].chan, vecs[t].start_ltc, vecs[t].end_ltc);
      @(posedge clk);
      #1 ovf_req[vecs[t].chan] = 1'b1;
      wait_valid(10, k, ok);
      check($sformatf("v%0d_latency", t), k, ok ? vecs[t].exp_latency : -1);
      check($sformatf("v%0d_chan", t),  rec_chan, vecs[t].chan);
      check($sformatf("v%0d_start", t), rec_start_ltc, vecs[t].start_ltc);
      check($sformatf("v%0d_end", t),   rec_end_ltc, vecs[t].end_ltc);
      @(negedge clk);
      check($sformatf("v%0d_ack", t),   ovf_ack, 24'd1 << vecs[t].chan);
      check($sformatf("v%0d_vdrop", t), rec_valid, 0);
      check($sformatf("v%0d_count", t), rec_count, vecs[t].exp_count);
      ovf_req[vecs[t].chan] = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_ack_pulse", t), ovf_ack, 0);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_idle", t), busy, 0);
    end

    // Round robin over channels 0, 5, 23 requesting continuously from reset.
    @(negedge clk);
    rst = 1'b1;
    ovf_req = '0;
    ovf_req[0] = 1'b1;
    ovf_req[5] = 1'b1;
    ovf_req[23] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_seen = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      order[i] = -1;
      at[i] = -100;
    end
    for (int c = 0; c < 25 && n_seen < 4; c++) begin
      @(negedge clk);
      if (ovf_ack != '0) begin
        if (!$onehot(ovf_ack)) bad++;
        for (int b = 0; b < NC; b++)
          if (ovf_ack[b]) order[n_seen] = b;
        at[n_seen] = c;
        n_seen++;
      end
    end
    check("rr_onehot", bad, 0);
    check("rr_acks",   n_seen, 4);
    check("rr_order0", order[0], 0);
    check("rr_order1", order[1], 5);
    check("rr_order2", order[2], 23);
    check("rr_order3", order[3], 0);
    check("rr_gap01",  at[1] - at[0], 5);
    check("rr_gap12",  at[2] - at[1], 5);
    check("rr_gap23",  at[3] - at[2], 5);

    // Backpressure: record held for 20 cycles, ack only after acceptance.
    do_reset();
    rec_ready = 1'b0;
    set_rec(10, 49'h0_1234_5678_9AB, 49'h7);
    @(posedge clk);
    #1 ovf_req[10] = 1'b1;
    wait_valid(10, k, ok);
    check("bp_valid", ok, 1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rec_valid || rec_chan != 10 || rec_start_ltc != 49'h0_1234_5678_9AB ||
          rec_end_ltc != 49'h7 || ovf_ack != '0)
        bad++;
    end
    check("bp_hold", bad, 0);
    rec_ready = 1'b1;
    @(negedge clk);
    check("bp_ack",   ovf_ack, 24'd1 << 10);
    check("bp_vdrop", rec_valid, 0);
    check("bp_count", rec_count, 1);
    ovf_req[10] = 1'b0;
    repeat (4) @(negedge clk);

    // Withdrawn request: channel 7 pulses for a single cycle.
    do_reset();
    set_rec(7, 49'd77, 49'd78);
    @(posedge clk);
    #1 ovf_req[7] = 1'b1;
    @(posedge clk);
    #1 ovf_req[7] = 1'b0;
    n_valid = 0;
    n_ack = 0;
    saw_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (rec_valid) n_valid++;
      if (ovf_ack != '0) n_ack++;
      if (busy) saw_busy = 1;
    end
    check("wd_granted", saw_busy, 1);
    check("wd_valid",   n_valid, 0);
    check("wd_ack",     n_ack, 0);
    check("wd_count",   rec_count, 0);
    check("wd_idle",    busy, 0);

    // Asynchronous reset while a record is presented.
    do_reset();
    rec_ready = 1'b0;
    set_rec(12, 49'h1_0000_0000_0001, 49'h0_ABCD);
    @(posedge clk);
    #1 ovf_req[12] = 1'b1;
    wait_valid(10, k, ok);
    check("rp_valid_before", ok, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rp_valid", rec_valid, 0);
    check("rp_chan",  rec_chan, 0);
    check("rp_start", rec_start_ltc, 0);
    check("rp_end",   rec_end_ltc, 0);
    check("rp_busy",  busy, 0);
    check("rp_ack",   ovf_ack, 0);
    @(negedge clk);
    rst = 1'b0;
    rec_ready = 1'b1;
    n_valid = 0;
    n_ack = 0;
    got_chan = '0;
    got_s = '0;
    got_e = '0;
    repeat (15) begin
      @(negedge clk);
      if (rec_valid) begin
        n_valid++;
        got_chan = rec_chan;
        got_s = rec_start_ltc;
        got_e = rec_end_ltc;
      end
      if (ovf_ack != '0) begin
        n_ack++;
        if (ovf_ack == (24'd1 << 12)) ovf_req[12] = 1'b0;
      end
    end
    check("rp_presented", n_valid, 1);
    check("rp_rchan",     got_chan, 12);
    check("rp_rstart",    got_s, 49'h1_0000_0000_0001);
    check("rp_rend",      got_e, 49'h0_ABCD);
    check("rp_acks",      n_ack, 1);
    check("rp_count",     rec_count, 1);

    // Enable low blocks grants; then counter wraps on the next record.
    do_reset();
    en = 1'b0;
    set_rec(2, 49'd2000, 49'd2001);
    ovf_req[2] = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || rec_valid || ovf_ack != '0) bad++;
    end
    check("en_blocked", bad, 0);
    force dut.r_rec_count = '1;
    #1 release dut.r_rec_count;
    @(negedge clk);
    check("en_preload", rec_count, 32'hFFFF_FFFF);
    en = 1'b1;
    wait_ack(10, ok);
    check("en_ack",   ovf_ack, ok ? (24'd1 << 2) : 24'hFFFFFF);
    check("en_wrap",  rec_count, 0);
    ovf_req[2] = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
